// File: rtl/bcd_pkg.sv
// Shared BCD digit type, decade limits and digit validation helper for the
// multi-digit BCD counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic is_bcd(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage: holds a single BCD digit, steps up or down when told to,
// and flags when it sits at the rollover limit for the current direction.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       step,
  input  logic       up,
  output bcd_digit_t q,
  output logic       at_limit
);

  bcd_digit_t q_next;

  assign at_limit = up ? (q == BCD_MAX) : (q == BCD_MIN);

  always_comb begin
    q_next = q;
    if (load) begin
      // Non-BCD load digits are forced to zero so the stage never holds >9.
      q_next = is_bcd(load_d) ? load_d : BCD_MIN;
    end else if (step) begin
      if (up) begin
        q_next = (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q_next = (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= BCD_MIN;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// DIGITS-wide BCD up/down counter with validated parallel load, terminal
// count, wrap pulse and load error pulse. Define BCD_CNT_SAT_EN to saturate
// at the range ends instead of wrapping.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  logic [DIGITS-1:0] at_limit;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   chain;
  logic              all_limit;
  logic              advance;
  logic              bad_digit;

  // chain[i] is high when every digit below i is at its limit, so digit i
  // moves on this edge; the whole carry is resolved combinationally.
  assign chain[0]  = 1'b1;
  assign all_limit = chain[DIGITS];
  assign tc        = all_limit;

`ifdef BCD_CNT_SAT_EN
  assign advance = en & ~load & ~all_limit;
`else
  assign advance = en & ~load;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] & at_limit[i];
    assign step[i]    = advance & chain[i];

    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_d   (load_val[4*i +: 4]),
      .step     (step[i]),
      .up       (up),
      .q        (count[4*i +: 4]),
      .at_limit (at_limit[i])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(load_val[4*i +: 4])) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= load & bad_digit;
`ifdef BCD_CNT_SAT_EN
      wrap     <= 1'b0;
`else
      wrap     <= advance & all_limit;
`endif
    end
  end

endmodule
